// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//
// Input front-end that turns raw, bouncy game-pad signals into clean
// per-button levels and single-cycle event strobes. Each channel has a
// 2-FF synchroniser, a debounce counter, and press/release strobes. An
// optional hold-to-autorepeat strobe is built only when the macro
// BUTTON_AUTOREPEAT_EN is defined. Otherwise btn_repeat is tied low and the
// port list is unchanged.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       wrapper active; low synchronously clears debounce/repeat state
//   btn_in       raw asynchronous pad inputs (NUM_BTN)
//   btn_level    debounced level, 1 = pressed (NUM_BTN)
//   btn_press    one-cycle strobe on accepted press (NUM_BTN)
//   btn_release  one-cycle strobe on accepted release (NUM_BTN)
//   btn_repeat   one-cycle autorepeat strobe (NUM_BTN)
//   any_press    OR of btn_press, same cycle
// ----------------------------------------------------------------------------
module button_conditioner #(
    parameter int unsigned NUM_BTN      = 4,
    parameter int unsigned DB_CYCLES    = 250000,
    parameter int unsigned ACTIVE_LOW   = 0,
    parameter int unsigned REPEAT_DELAY = 6250000,
    parameter int unsigned REPEAT_RATE  = 2500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic               any_press
);

    localparam int unsigned   CW     = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

    logic [NUM_BTN-1:0] w_pad;
    logic [NUM_BTN-1:0] r_s1;
    logic [NUM_BTN-1:0] r_s2;
    logic [NUM_BTN-1:0] r_level;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_release;
    logic [CW-1:0]      r_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] w_mismatch;
    logic [NUM_BTN-1:0] w_done;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_fall;

    // Normalise polarity before synchronising so that 1 always means pressed.
    assign w_pad = btn_in ^ {NUM_BTN{ACTIVE_LOW != 0}};

    // The synchroniser ignores enable so s2 is already valid when enable returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_pad;
            r_s2 <= r_s1;
        end
    end

    // A channel completes when it has disagreed with its level for DB_CYCLES
    // consecutive enabled edges.
    always_comb begin
        w_mismatch = r_s2 ^ r_level;
        w_done     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_done[i] = w_mismatch[i] && (r_cnt[i] == DB_MAX);
        end
        w_rise = w_done & r_s2;
        w_fall = w_done & ~r_s2;
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_level   <= r_level ^ w_done;
            r_press   <= w_rise;
            r_release <= w_fall;
            for (int i = 0; i < NUM_BTN; i++) begin
                // Any agreement (bounce back) or an accepted change restarts the count.
                if (!w_mismatch[i] || w_done[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int unsigned   RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                                       : REPEAT_RATE;
    localparam int unsigned   RW       = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DLY_MAX  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_MAX = RW'(REPEAT_RATE - 1);

    logic [RW-1:0]      r_rcnt [NUM_BTN];
    logic [NUM_BTN-1:0] r_rlater;  // 0: waiting out the initial delay, 1: steady rate
    logic [NUM_BTN-1:0] r_repeat;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_repeat <= '0;
            r_rlater <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_rcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_repeat[i] <= 1'b0;
                // Press edge restarts the delay; release edge wins over a due repeat.
                if (w_rise[i] || w_fall[i] || !r_level[i]) begin
                    r_rcnt[i]   <= '0;
                    r_rlater[i] <= 1'b0;
                end else if (r_rcnt[i] == (r_rlater[i] ? RATE_MAX : DLY_MAX)) begin
                    r_repeat[i] <= 1'b1;
                    r_rcnt[i]   <= '0;
                    r_rlater[i] <= 1'b1;
                end else begin
                    r_rcnt[i] <= r_rcnt[i] + RW'(1);
                end
            end
        end
    end

    assign btn_repeat = r_repeat;
`else
    logic [31:0] w_unused_rpt;
    assign w_unused_rpt = REPEAT_DELAY ^ REPEAT_RATE;
    assign btn_repeat   = '0;
`endif

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign any_press   = |r_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner. Four instances cover the parameter corners:
//   0: DB_CYCLES=4, active-high
//   1: DB_CYCLES=4, active-low
//   2: DB_CYCLES=2, REPEAT_DELAY=10, REPEAT_RATE=4
//   3: DB_CYCLES=1
// Expected strobe events are queued per instance with the cycle they must
// appear on; a negedge monitor pops and compares every strobe it sees.
module tb_button_conditioner;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [3:0]  rpt;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en   [4];
    logic [3:0]  btn  [4];
    logic [3:0]  lvl  [4];
    logic [3:0]  prs  [4];
    logic [3:0]  rls  [4];
    logic [3:0]  rpt  [4];
    logic        anyp [4];

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    ev_t         sb_q [4][$];
    ev_t         ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_conditioner #(.NUM_BTN(4), .DB_CYCLES(4), .ACTIVE_LOW(0)) u_a (
        .clk(clk), .reset(reset), .enable(en[0]), .btn_in(btn[0]), .btn_level(lvl[0]),
        .btn_press(prs[0]), .btn_release(rls[0]), .btn_repeat(rpt[0]), .any_press(anyp[0])
    );
    button_conditioner #(.NUM_BTN(4), .DB_CYCLES(4), .ACTIVE_LOW(1)) u_b (
        .clk(clk), .reset(reset), .enable(en[1]), .btn_in(btn[1]), .btn_level(lvl[1]),
        .btn_press(prs[1]), .btn_release(rls[1]), .btn_repeat(rpt[1]), .any_press(anyp[1])
    );
    button_conditioner #(.NUM_BTN(4), .DB_CYCLES(2), .ACTIVE_LOW(0), .REPEAT_DELAY(10),
                         .REPEAT_RATE(4)) u_c (
        .clk(clk), .reset(reset), .enable(en[2]), .btn_in(btn[2]), .btn_level(lvl[2]),
        .btn_press(prs[2]), .btn_release(rls[2]), .btn_repeat(rpt[2]), .any_press(anyp[2])
    );
    button_conditioner #(.NUM_BTN(4), .DB_CYCLES(1), .ACTIVE_LOW(0)) u_d (
        .clk(clk), .reset(reset), .enable(en[3]), .btn_in(btn[3]), .btn_level(lvl[3]),
        .btn_press(prs[3]), .btn_release(rls[3]), .btn_repeat(rpt[3]), .any_press(anyp[3])
    );

    // Scoreboard monitor: every strobe must match the next queued event exactly.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if ((prs[d] | rls[d] | rpt[d]) != 4'd0) begin
                n_checks++;
                if (sb_q[d].size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected dut%0d cyc=%0d got press=%b rel=%b rpt=%b, required none",
                             d, cyc, prs[d], rls[d], rpt[d]);
                end else begin
                    ev = sb_q[d].pop_front();
                    if (ev.cyc != cyc || ev.press !== prs[d] || ev.rel !== rls[d] ||
                        ev.rpt !== rpt[d]) begin
                        n_errors++;
                        $display("FAIL sb_event dut%0d got cyc=%0d press=%b rel=%b rpt=%b, required cyc=%0d press=%b rel=%b rpt=%b",
                                 d, cyc, prs[d], rls[d], rpt[d], ev.cyc, ev.press, ev.rel, ev.rpt);
                    end
                end
            end
        end
    end

    task automatic sb_push(input int d, input int unsigned at, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] q);
        ev_t e;
        e.cyc = at; e.press = p; e.rel = r; e.rpt = q;
        sb_q[d].push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(3);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if ({lvl[d], prs[d], rls[d], rpt[d], anyp[d]} !== 17'd0) begin
                n_errors++;
                $display("FAIL reset_outputs dut%0d got=%h required=0", d,
                         {lvl[d], prs[d], rls[d], rpt[d], anyp[d]});
            end
        end
        reset = 1'b0;
        step(3);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (lvl[d] !== 4'd0) begin
                n_errors++;
                $display("FAIL post_reset_level dut%0d got=%b required=0000", d, lvl[d]);
            end
        end
    endtask

    // Clean press: level and strobe on E6 for DB_CYCLES=4, strobe gone on E7.
    task automatic test_press;
        int unsigned c;
        c = cyc;
        btn[0][0] = 1'b1;
        sb_push(0, c + 6, 4'b0001, 4'b0000, 4'b0000);
        step(5);
        n_checks++;
        if (lvl[0] !== 4'b0000 || anyp[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL press_e5 got lvl=%b any=%b required lvl=0000 any=0", lvl[0], anyp[0]);
        end
        step(1);
        n_checks++;
        if (lvl[0] !== 4'b0001 || anyp[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL press_e6 got lvl=%b any=%b required lvl=0001 any=1", lvl[0], anyp[0]);
        end
        step(1);
        n_checks++;
        if (prs[0] !== 4'b0000 || anyp[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL press_e7 got press=%b any=%b required press=0000 any=0", prs[0], anyp[0]);
        end
    endtask

    // A 3-cycle pulse is one edge short of acceptance; a held level is accepted.
    task automatic test_bounce;
        int unsigned c;
        btn[0][1] = 1'b1;
        step(3);
        btn[0][1] = 1'b0;
        step(8);
        n_checks++;
        if (lvl[0] !== 4'b0001) begin
            n_errors++;
            $display("FAIL bounce_level got=%b required=0001", lvl[0]);
        end
        c = cyc;
        btn[0][1] = 1'b1;
        sb_push(0, c + 6, 4'b0010, 4'b0000, 4'b0000);
        step(6);
        n_checks++;
        if (lvl[0] !== 4'b0011) begin
            n_errors++;
            $display("FAIL bounce_held_level got=%b required=0011", lvl[0]);
        end
    endtask

    task automatic test_release;
        int unsigned c;
        c = cyc;
        btn[0][2] = 1'b1;
        sb_push(0, c + 6, 4'b0100, 4'b0000, 4'b0000);
        step(8);
        c = cyc;
        btn[0][2] = 1'b0;
        sb_push(0, c + 6, 4'b0000, 4'b0100, 4'b0000);
        step(5);
        n_checks++;
        if (lvl[0] !== 4'b0111) begin
            n_errors++;
            $display("FAIL release_e5 got=%b required=0111", lvl[0]);
        end
        step(1);
        n_checks++;
        if (lvl[0] !== 4'b0011) begin
            n_errors++;
            $display("FAIL release_e6 got=%b required=0011", lvl[0]);
        end
    endtask

    // Active-low: idle 4'hF is released; 4'hA presses channels 0 and 2 together.
    task automatic test_active_low;
        int unsigned c;
        step(100);
        n_checks++;
        if (lvl[1] !== 4'b0000) begin
            n_errors++;
            $display("FAIL al_idle got=%b required=0000", lvl[1]);
        end
        c = cyc;
        btn[1] = 4'hA;
        sb_push(1, c + 6, 4'b0101, 4'b0000, 4'b0000);
        step(6);
        n_checks++;
        if (lvl[1] !== 4'b0101 || anyp[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL al_press got lvl=%b any=%b required lvl=0101 any=1", lvl[1], anyp[1]);
        end
        c = cyc;
        btn[1] = 4'hF;
        sb_push(1, c + 6, 4'b0000, 4'b0101, 4'b0000);
        step(8);
    endtask

    // enable low for one edge drops held channels silently; they re-press on
    // the 4th enabled edge (5 edges after enable fell).
    task automatic test_enable;
        int unsigned c;
        c = cyc;
        en[0] = 1'b0;
        sb_push(0, c + 5, 4'b0011, 4'b0000, 4'b0000);
        step(1);
        en[0] = 1'b1;
        n_checks++;
        if (lvl[0] !== 4'b0000 || rls[0] !== 4'b0000) begin
            n_errors++;
            $display("FAIL en_clear got lvl=%b rel=%b required 0000/0000", lvl[0], rls[0]);
        end
        step(3);
        n_checks++;
        if (lvl[0] !== 4'b0000) begin
            n_errors++;
            $display("FAIL en_resume_early got=%b required=0000", lvl[0]);
        end
        step(1);
        n_checks++;
        if (lvl[0] !== 4'b0011) begin
            n_errors++;
            $display("FAIL en_resume got=%b required=0011", lvl[0]);
        end
        c = cyc;
        btn[0] = 4'b0000;
        sb_push(0, c + 6, 4'b0000, 4'b0011, 4'b0000);
        step(8);
    endtask

    // Reset with cnt=2 discards the count; acceptance restarts from scratch.
    task automatic test_reset_midcount;
        int unsigned c;
        c = cyc;
        btn[0][3] = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_checks++;
        if (lvl[0] !== 4'b0000) begin
            n_errors++;
            $display("FAIL rst_mid_level got=%b required=0000", lvl[0]);
        end
        sb_push(0, c + 11, 4'b1000, 4'b0000, 4'b0000);
        step(5);
        n_checks++;
        if (lvl[0] !== 4'b0000) begin
            n_errors++;
            $display("FAIL rst_mid_early got=%b required=0000", lvl[0]);
        end
        step(1);
        n_checks++;
        if (lvl[0] !== 4'b1000) begin
            n_errors++;
            $display("FAIL rst_mid_press got=%b required=1000", lvl[0]);
        end
        c = cyc;
        btn[0] = 4'b0000;
        sb_push(0, c + 6, 4'b0000, 4'b1000, 4'b0000);
        step(8);
    endtask

    // Press edge P = drive+4 (DB_CYCLES=2); repeats at P+10, P+14, P+18.
    task automatic test_autorepeat;
        int unsigned p;
        p = cyc + 4;
        btn[2] = 4'b0001;
        sb_push(2, p, 4'b0001, 4'b0000, 4'b0000);
`ifdef BUTTON_AUTOREPEAT_EN
        sb_push(2, p + 10, 4'b0000, 4'b0000, 4'b0001);
        sb_push(2, p + 14, 4'b0000, 4'b0000, 4'b0001);
        sb_push(2, p + 18, 4'b0000, 4'b0000, 4'b0001);
`endif
        step(4);
        n_checks++;
        if (lvl[2] !== 4'b0001 || rpt[2] !== 4'b0000) begin
            n_errors++;
            $display("FAIL ar_press got lvl=%b rpt=%b required 0001/0000", lvl[2], rpt[2]);
        end
        step(10);
        n_checks++;
`ifdef BUTTON_AUTOREPEAT_EN
        if (rpt[2] !== 4'b0001) begin
            n_errors++;
            $display("FAIL ar_first got=%b required=0001", rpt[2]);
        end
`else
        if (rpt[2] !== 4'b0000) begin
            n_errors++;
            $display("FAIL ar_disabled got=%b required=0000", rpt[2]);
        end
`endif
        step(7);
        btn[2] = 4'b0000;
        sb_push(2, p + 21, 4'b0000, 4'b0001, 4'b0000);
        step(4);
        n_checks++;
        if (lvl[2] !== 4'b0000) begin
            n_errors++;
            $display("FAIL ar_release got=%b required=0000", lvl[2]);
        end
        step(20);
    endtask

    // DB_CYCLES=1: acceptance on E3 in both directions.
    task automatic test_db1;
        int unsigned c;
        c = cyc;
        btn[3] = 4'b0010;
        sb_push(3, c + 3, 4'b0010, 4'b0000, 4'b0000);
        step(2);
        n_checks++;
        if (lvl[3] !== 4'b0000) begin
            n_errors++;
            $display("FAIL db1_e2 got=%b required=0000", lvl[3]);
        end
        step(1);
        n_checks++;
        if (lvl[3] !== 4'b0010) begin
            n_errors++;
            $display("FAIL db1_e3 got=%b required=0010", lvl[3]);
        end
        c = cyc;
        btn[3] = 4'b0000;
        sb_push(3, c + 3, 4'b0000, 4'b0010, 4'b0000);
        step(5);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 4; d++) begin
            en[d]  = 1'b1;
            btn[d] = 4'b0000;
        end
        btn[1] = 4'hF;
        @(negedge clk);
        test_reset;
        test_press;
        test_bounce;
        test_release;
        test_active_low;
        test_enable;
        test_reset_midcount;
        test_autorepeat;
        test_db1;
        step(5);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (sb_q[d].size() != 0) begin
                n_errors++;
                $display("FAIL sb_pending dut%0d got=%0d outstanding events required=0", d,
                         sb_q[d].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
